// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared state, opcode and select encodings for the multi-cycle controller
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_SD    = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // States that own the memory port and therefore run the wait timer
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - shared instruction/data memory request/ack port
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ack);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// rtl/multicycle_ctrl_fsm_mem_wait_timer.sv - counts unacknowledged memory cycles, flags TIMEOUT-1
module multicycle_ctrl_fsm_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV64 subset datapath
// Optional perf counters cyc_cnt/ret_cnt are built when CTRL_PERF_EN is defined.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT = 16
`ifdef CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [6:0]            opcode,
  input  logic                  alu_zero,
  multicycle_ctrl_fsm_if.master mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic                  reg_we,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  busy,
  output logic                  trap,
  output logic [1:0]            trap_cause
`ifdef CTRL_PERF_EN
  , output logic [CNT_W-1:0]    cyc_cnt
  , output logic [CNT_W-1:0]    ret_cnt
`endif
);

  state_t     state, state_next;
  logic       mem_req, mem_we, i_or_d;
  logic       retire, expired;
  logic [1:0] cause_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trap_cause <= TRAP_NONE;
    end else begin
      state <= state_next;
      if (state != S_TRAP && state_next == S_TRAP) trap_cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = TRAP_NONE;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RS2;
    alu_op     = ALUOP_ADD;
    unique case (state)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem.mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM;
        case (opcode)
          OPC_RTYPE:      state_next = S_R_EXEC;
          OPC_LD, OPC_SD: state_next = S_MEM_ADDR;
          OPC_BEQ:        state_next = S_BRANCH;
          default: begin
            state_next = S_TRAP;
            cause_next = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUB_IMM;
        state_next = (opcode == OPC_SD) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem.mem_ack) begin
          state_next = S_LD_WB;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = TRAP_TIMEOUT;
        end
      end
      S_LD_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem.mem_ack) begin
          retire = 1'b1;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = TRAP_TIMEOUT;
        end
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_we     = alu_zero;
        retire    = 1'b1;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
    // run is only honoured at the instruction boundary
    if (retire) state_next = run ? S_FETCH : S_IDLE;
  end

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign mem.i_or_d  = i_or_d;
  assign busy        = (state != S_IDLE) && (state != S_TRAP);
  assign trap        = (state == S_TRAP);

  multicycle_ctrl_fsm_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (is_mem_state(state_next) && (state_next != state)),
    .count_en (mem_req && !mem.mem_ack),
    .expired  (expired)
  );

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (busy)   cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (retire) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
